// File: rtl/cpu_boot_ctrl.sv
// cpu_boot_ctrl: streams a program image into the CPU memories, releases the CPU
// from reset and supervises the run until halt or timeout.
module cpu_boot_ctrl #(
    parameter logic [31:0] MAX_CYCLES = 32'd1000000
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    output logic        s_ready,
    output logic        ex_iwe,
    output logic [15:0] ex_iaddr,
    output logic [15:0] ex_idata,
    output logic        ex_dwe,
    output logic [15:0] ex_daddr,
    output logic [15:0] ex_ddata,
    output logic        cpu_rst_n,
    input  logic        flag_done,
    input  logic [15:0] out_r,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] cycles,
    output logic [15:0] result,
    output logic [7:0]  result_cnt
);
    typedef enum logic [3:0] {IDLE, I_HDR, I_LOAD, D_HDR, D_LOAD, RELEASE, RUN, DONE, TIMEOUT} state_t;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, idx_q, idx_d, idx_nx;
    logic        iwe_q, iwe_d, dwe_q, dwe_d, cpu_rst_n_q, cpu_rst_n_d;
    logic [15:0] iaddr_q, iaddr_d, idata_q, idata_d, daddr_q, daddr_d, ddata_q, ddata_d;
    logic [31:0] cycles_q, cycles_d;
    logic [15:0] result_q, result_d;
    logic [7:0]  result_cnt_q, result_cnt_d;
    logic        accept, last;

    assign s_ready = state_q inside {I_HDR, I_LOAD, D_HDR, D_LOAD};
    assign accept  = s_valid & s_ready;
    assign idx_nx  = idx_q + 16'd1;
    assign last    = idx_nx == cnt_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        iwe_d        = 1'b0;
        iaddr_d      = 16'd0;
        idata_d      = 16'd0;
        dwe_d        = 1'b0;
        daddr_d      = 16'd0;
        ddata_d      = 16'd0;
        cycles_d     = cycles_q;
        result_d     = result_q;
        result_cnt_d = result_cnt_q;
        case (state_q)
            IDLE: if (start) state_d = I_HDR;
            I_HDR: if (accept) begin
                cnt_d   = s_data;
                idx_d   = 16'd0;
                state_d = (s_data != 16'd0) ? I_LOAD : D_HDR;
            end
            I_LOAD: if (accept) begin
                iwe_d   = 1'b1;
                iaddr_d = idx_q;
                idata_d = s_data;
                idx_d   = idx_nx;
                if (last) state_d = D_HDR;
            end
            D_HDR: if (accept) begin
                cnt_d   = s_data;
                idx_d   = 16'd0;
                state_d = (s_data != 16'd0) ? D_LOAD : RELEASE;
            end
            D_LOAD: if (accept) begin
                dwe_d   = 1'b1;
                daddr_d = idx_q;
                ddata_d = s_data;
                idx_d   = idx_nx;
                if (last) state_d = RELEASE;
            end
            RELEASE: begin
                cycles_d     = 32'd0;
                result_d     = 16'd0;
                result_cnt_d = 8'd0;
                state_d      = RUN;
            end
            RUN: begin
                if (out_r != 16'd0) begin
                    result_d     = out_r;
                    result_cnt_d = result_cnt_q + {7'd0, result_cnt_q != 8'hFF};
                end
                // the cycle that leaves RUN is not counted, so cycles reports completed run cycles
                if (flag_done) state_d = DONE;
                else if (MAX_CYCLES != 32'd0 && cycles_q == MAX_CYCLES - 32'd1) state_d = TIMEOUT;
                else cycles_d = cycles_q + {31'd0, cycles_q != 32'hFFFF_FFFF};
            end
            DONE, TIMEOUT: if (start) state_d = I_HDR;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            iwe_d   = 1'b0;
            iaddr_d = 16'd0;
            idata_d = 16'd0;
            dwe_d   = 1'b0;
            daddr_d = 16'd0;
            ddata_d = 16'd0;
        end
        cpu_rst_n_d = state_d inside {RUN, DONE};
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 16'd0;
            idx_q        <= 16'd0;
            iwe_q        <= 1'b0;
            iaddr_q      <= 16'd0;
            idata_q      <= 16'd0;
            dwe_q        <= 1'b0;
            daddr_q      <= 16'd0;
            ddata_q      <= 16'd0;
            cpu_rst_n_q  <= 1'b0;
            cycles_q     <= 32'd0;
            result_q     <= 16'd0;
            result_cnt_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            iwe_q        <= iwe_d;
            iaddr_q      <= iaddr_d;
            idata_q      <= idata_d;
            dwe_q        <= dwe_d;
            daddr_q      <= daddr_d;
            ddata_q      <= ddata_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            cycles_q     <= cycles_d;
            result_q     <= result_d;
            result_cnt_q <= result_cnt_d;
        end
    end

    assign ex_iwe     = iwe_q;
    assign ex_iaddr   = iaddr_q;
    assign ex_idata   = idata_q;
    assign ex_dwe     = dwe_q;
    assign ex_daddr   = daddr_q;
    assign ex_ddata   = ddata_q;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign busy       = !(state_q inside {IDLE, DONE, TIMEOUT});
    assign done       = state_q == DONE;
    assign timeout    = state_q == TIMEOUT;
    assign cycles     = cycles_q;
    assign result     = result_q;
    assign result_cnt = result_cnt_q;
endmodule
